invader_grid: RTL and testbench

INVADER_GRID -- requirements
Module: invader_grid

---
 rtl/invader_grid.sv | 196 +++++++++++++++++++
 tb/tb_invader_grid.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/invader_grid.sv
// invader_grid: 4x8 invader formation for the arcade core.
// Tracks which invaders are alive, marches the formation across the
// 32x16 playfield, tests the player bullet against the formation and
// reports clear / landed status.
// Optional feature: define INVADER_SPEEDUP_EN to halve the march period
// once 8 or fewer invaders remain. Without it the period is fixed.
//
// Bullet/hit contract: there is no handshake on the bullet inputs. They
// are sampled every cycle and i_bullet_active acts as a plain valid with
// no ready. o_hit is a registered single-cycle pulse, one per destroyed
// invader. The consumer must take it on the cycle it appears.
//
// o_state exposes the FSM for observation:
// 0 = IDLE, 1 = MARCH, 2 = CLEARED, 3 = LANDED.
module invader_grid #(
    parameter int STEP_TICKS = 18000000
) (
    input  logic        i_clk_36MHz,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_bullet_active,
    input  logic [4:0]  i_bullet_x,
    input  logic [3:0]  i_bullet_y,
    output logic        o_hit,
    output logic [31:0] o_alive,
    output logic [4:0]  o_offset_x,
    output logic [3:0]  o_offset_y,
    output logic        o_cleared,
    output logic        o_landed,
    output logic [1:0]  o_state
);

    localparam int CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CW-1:0] LAST_SLOW = CW'(STEP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MARCH   = 2'd1,
        CLEARED = 2'd2,
        LANDED  = 2'd3
    } state_t;

    state_t        state;
    logic          dir_left;
    logic [CW-1:0] count;
    logic [CW-1:0] last;

    logic [4:0]    dx;
    logic [3:0]    dy;
    logic          in_box;
    logic [4:0]    hit_idx;
    logic          hit_now;
    logic [31:0]   alive_nxt;

    logic [7:0]    col_any;
    logic [2:0]    right_col;
    logic [5:0]    right_x;
    logic          at_right;
    logic          at_left;
    logic          step_now;
    logic [4:0]    offx_nxt;
    logic [3:0]    offy_nxt;
    logic          dir_nxt;
    logic [1:0]    low_row;
    logic          land_now;

    assign o_state = state;

`ifdef INVADER_SPEEDUP_EN
    localparam int HALF = (STEP_TICKS / 2 > 0) ? STEP_TICKS / 2 : 1;
    localparam logic [CW-1:0] LAST_FAST = CW'(HALF - 1);
    logic [5:0] population;

    // Count live invaders and pick the faster period for a thin formation.
    always_comb begin
        population = 6'd0;
        for (int i = 0; i < 32; i++) begin
            population = population + {5'd0, o_alive[i]};
        end
        last = (population <= 6'd8) ? LAST_FAST : LAST_SLOW;
    end
`else
    assign last = LAST_SLOW;
`endif

    // Collision: locate the bullet relative to the origin with unsigned
    // compares only, so cells left of or above the formation never alias.
    always_comb begin
        dx      = i_bullet_x - o_offset_x;
        dy      = i_bullet_y - o_offset_y;
        in_box  = (i_bullet_x >= o_offset_x) && (i_bullet_y >= o_offset_y) &&
                  (dx <= 5'd14) && (dy <= 4'd3) && !dx[0];
        hit_idx = {dy[1:0], dx[3:1]};
        hit_now = i_bullet_active && in_box && o_alive[hit_idx];
        alive_nxt = o_alive;
        if (hit_now) begin
            alive_nxt[hit_idx] = 1'b0;
        end
    end

    // March: edge tests use the mask from before this cycle's hit.
    // The origin cannot go below 0, so a formation whose left columns
    // are gone reverses once the origin itself reaches 0.
    always_comb begin
        for (int c = 0; c < 8; c++) begin
            col_any[c] = o_alive[c] | o_alive[8 + c] | o_alive[16 + c] | o_alive[24 + c];
        end
        right_col = 3'd0;
        for (int c = 0; c < 8; c++) begin
            if (col_any[c]) begin
                right_col = 3'(c);
            end
        end
        right_x  = {1'b0, o_offset_x} + {2'b00, right_col, 1'b0};
        at_right = (right_x >= 6'd31);
        at_left  = (o_offset_x == 5'd0);
        step_now = (count >= last);

        offx_nxt = o_offset_x;
        offy_nxt = o_offset_y;
        dir_nxt  = dir_left;
        if (step_now) begin
            if (!dir_left) begin
                if (at_right) begin
                    offy_nxt = o_offset_y + 4'd1;
                    dir_nxt  = 1'b1;
                end else begin
                    offx_nxt = o_offset_x + 5'd1;
                end
            end else begin
                if (at_left) begin
                    offy_nxt = o_offset_y + 4'd1;
                    dir_nxt  = 1'b0;
                end else begin
                    offx_nxt = o_offset_x - 5'd1;
                end
            end
        end
    end

    // Landing: lowest surviving row after this cycle's hit and step.
    always_comb begin
        low_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (|alive_nxt[r*8 +: 8]) begin
                low_row = 2'(r);
            end
        end
        land_now = ({1'b0, offy_nxt} + {3'b000, low_row}) >= 5'd14;
    end

    // Wave FSM with registered outputs; start reloads from any state.
    always_ff @(posedge i_clk_36MHz) begin
        if (i_reset) begin
            state      <= IDLE;
            o_alive    <= 32'hFFFF_FFFF;
            o_offset_x <= 5'd0;
            o_offset_y <= 4'd0;
            dir_left   <= 1'b0;
            count      <= '0;
            o_hit      <= 1'b0;
            o_cleared  <= 1'b0;
            o_landed   <= 1'b0;
        end else begin
            o_hit <= 1'b0;
            if (i_start) begin
                state      <= MARCH;
                o_alive    <= 32'hFFFF_FFFF;
                o_offset_x <= 5'd0;
                o_offset_y <= 4'd0;
                dir_left   <= 1'b0;
                count      <= '0;
                o_cleared  <= 1'b0;
                o_landed   <= 1'b0;
            end else if (state == MARCH) begin
                o_alive <= alive_nxt;
                o_hit   <= hit_now;
                count   <= step_now ? '0 : count + CW'(1);
                if (alive_nxt == 32'd0) begin
                    // Clearing the last invader wins over a step or a landing.
                    state     <= CLEARED;
                    o_cleared <= 1'b1;
                end else begin
                    o_offset_x <= offx_nxt;
                    o_offset_y <= offy_nxt;
                    dir_left   <= dir_nxt;
                    if (land_now) begin
                        state    <= LANDED;
                        o_landed <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_invader_grid.sv
// Bench for invader_grid: a cell-level reference model predicts every
// output after each clock edge; a monitor pops those predictions and
// compares them against the design.
module tb_invader_grid;

    localparam int STEP = 4;
    localparam int W = 46;
`ifdef INVADER_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif
    localparam int S_IDLE = 0, S_MARCH = 1, S_CLEARED = 2, S_LANDED = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        b_act = 1'b0;
    logic [4:0]  b_x = 5'd0;
    logic [3:0]  b_y = 4'd0;
    logic        hit;
    logic [31:0] alive;
    logic [4:0]  off_x;
    logic [3:0]  off_y;
    logic        cleared;
    logic        landed;
    logic [1:0]  state;

    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state (post-edge values).
    logic [31:0] m_alive;
    int m_offx, m_offy, m_count, m_state;
    bit m_left, m_hit, m_cleared, m_landed;

    invader_grid #(.STEP_TICKS(STEP)) dut (
        .i_clk_36MHz    (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_bullet_active(b_act),
        .i_bullet_x     (b_x),
        .i_bullet_y     (b_y),
        .o_hit          (hit),
        .o_alive        (alive),
        .o_offset_x     (off_x),
        .o_offset_y     (off_y),
        .o_cleared      (cleared),
        .o_landed       (landed),
        .o_state        (state)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: one clock edge worth of behaviour, from the game rules.
    task automatic model_edge(input bit r, input bit s, input bit ba, input int bx, input int by);
        int hit_i, period, maxc, minc, maxr;
        bit step;
        logic [31:0] na;
        m_hit = 1'b0;
        if (r) begin
            m_state = S_IDLE; m_alive = '1; m_offx = 0; m_offy = 0; m_left = 0;
            m_count = 0; m_cleared = 0; m_landed = 0;
        end else if (s) begin
            m_state = S_MARCH; m_alive = '1; m_offx = 0; m_offy = 0; m_left = 0;
            m_count = 0; m_cleared = 0; m_landed = 0;
        end else if (m_state == S_MARCH) begin
            hit_i = -1;
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 8; col++)
                    if (m_alive[row*8+col] && ba && bx == m_offx + 2*col && by == m_offy + row)
                        hit_i = row*8 + col;
            na = m_alive;
            if (hit_i >= 0) na[hit_i] = 1'b0;
            m_hit = (hit_i >= 0);
            period = (SPEEDUP && $countones(m_alive) <= 8) ? STEP/2 : STEP;
            step = (m_count >= period - 1);
            m_count = step ? 0 : m_count + 1;
            if (na == 0) begin
                m_alive = na; m_state = S_CLEARED; m_cleared = 1;
            end else begin
                if (step) begin
                    maxc = 0; minc = 7;
                    for (int i = 0; i < 32; i++) if (m_alive[i]) begin
                        if (i % 8 > maxc) maxc = i % 8;
                        if (i % 8 < minc) minc = i % 8;
                    end
                    if (!m_left) begin
                        if (m_offx + 2*maxc >= 31) begin m_offy++; m_left = 1; end
                        else m_offx++;
                    end else begin
                        if (m_offx + 2*minc == 0 || m_offx == 0) begin m_offy++; m_left = 0; end
                        else m_offx--;
                    end
                end
                m_alive = na;
                maxr = 0;
                for (int i = 0; i < 32; i++) if (m_alive[i] && i / 8 > maxr) maxr = i / 8;
                if (m_offy + maxr >= 14) begin m_state = S_LANDED; m_landed = 1; end
            end
        end
    endtask

    // Driver: apply one cycle of inputs and queue the predicted response.
    task automatic drive(input bit r, input bit s, input bit ba, input int bx, input int by);
        @(negedge clk);
        rst = r; start = s; b_act = ba; b_x = 5'(bx); b_y = 4'(by);
        model_edge(r, s, ba, bx, by);
        exp_q.push_back({2'(m_state), m_landed, m_cleared, m_hit, 4'(m_offy), 5'(m_offx), m_alive});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0);
    endtask

    // Aim at invader i at the formation's current position.
    task automatic aim(input int i);
        drive(0, 0, 1, m_offx + 2*(i % 8), m_offy + i / 8);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [W-1:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state, landed, cleared, hit, off_y, off_x, alive};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs cycle %0d: got state=%0d landed=%b cleared=%b hit=%b oy=%0d ox=%0d alive=%h, expected state=%0d landed=%b cleared=%b hit=%b oy=%0d ox=%0d alive=%h",
                             cyc, a[45:44], a[43], a[42], a[41], a[40:37], a[36:32], a[31:0],
                             e[45:44], e[43], e[42], e[41], e[40:37], e[36:32], e[31:0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int n, idx;
        // Reset, then IDLE with bullets flying: nothing may register.
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        for (int k = 0; k < 6; k++) drive(0, 0, 1, $urandom_range(0, 31), $urandom_range(0, 15));

        // Start; held bullet on (4,2) kills bit 18 once; misses on gap and inactive.
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 1, 4, 2);
        drive(0, 0, 1, 4, 2);
        drive(0, 0, 1, 4, 2);
        drive(0, 0, 1, 3, 0);
        drive(0, 0, 0, 0, 0);

        // March to the right edge and beyond the first descent.
        drive(0, 1, 0, 0, 0);
        idle(80);

        // Kill the whole wave, in random order, then sit in CLEARED.
        n = 0;
        while (m_alive != 0 && n < 2000) begin
            idx = $urandom_range(0, 31);
            if (m_alive[idx] && m_state == S_MARCH) aim(idx);
            n++;
        end
        for (int k = 0; k < 10; k++) drive(0, 0, 1, $urandom_range(0, 31), $urandom_range(0, 15));
        drive(0, 1, 0, 0, 0);

        // Let the formation land, then confirm it stays put.
        n = 0;
        while (m_state != S_LANDED && n < 3000) begin idle(1); n++; end
        if (m_state != S_LANDED) $display("FAIL landing model never reached LANDED");
        for (int k = 0; k < 12; k++) drive(0, 0, 1, $urandom_range(0, 31), $urandom_range(0, 15));

        // Reset in the middle of a march, coinciding with a hit and a step.
        drive(0, 1, 0, 0, 0);
        idle(11);
        drive(1, 0, 1, m_offx, m_offy);
        idle(3);

        // Thin the formation to 8 invaders and watch the march period.
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 24; i++) aim(i);
        idle(40);

        // Randomized mix.
        drive(0, 1, 0, 0, 0);
        for (int k = 0; k < 700; k++) begin
            if ($urandom_range(0, 299) == 0) drive(1, 0, 0, 0, 0);
            else if ($urandom_range(0, 119) == 0) drive(0, 1, $urandom_range(0, 1), 0, 0);
            else if ($urandom_range(0, 1) == 0) begin
                idx = $urandom_range(0, 31);
                if (m_alive[idx]) drive(0, 0, $urandom_range(0, 3) != 0,
                                        m_offx + 2*(idx % 8) + $urandom_range(0, 1), m_offy + idx / 8);
                else idle(1);
            end else drive(0, 0, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 15));
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
